// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge-magnitude filter, raster-order pixels in,
// one saturated gradient pixel per interior position out.
module sobel_stream #(
   parameter int DW    = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_pixel,
   input  logic          in_sof,
   input  logic [1:0]    mode,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_pixel,
   output logic          out_last
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int GW = DW + 4;
   localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
   localparam logic [GW-1:0] SAT  = GW'((1 << DW) - 1);

   logic [CW-1:0] col_q, col_d, c;
   logic [RW-1:0] row_q, row_d, r;
   logic [DW-1:0] lb1_q [IMG_W];
   logic [DW-1:0] lb2_q [IMG_W];
   logic [DW-1:0] t0_q, t1_q, m0_q, m1_q, b0_q, b1_q;
   logic [DW-1:0] p13, p23;
   logic          acc, inner;
   logic [GW-1:0] gx, gy, ax, ay, mag;
   logic          ov_q, ov_d, last_q, last_d;
   logic [DW-1:0] px_q, px_d;

   function automatic logic [GW-1:0] ext(input logic [DW-1:0] v);
      return GW'(v);
   endfunction

   assign in_ready  = !ov_q || out_ready;
   assign acc       = in_valid && in_ready;
   assign c         = in_sof ? '0 : col_q;
   assign r         = in_sof ? '0 : row_q;
   assign p13       = lb2_q[c];
   assign p23       = lb1_q[c];
   assign inner     = (r >= RW'(2)) && (c >= CW'(2));
   assign out_valid = ov_q;
   assign out_pixel = px_q;
   assign out_last  = last_q;

   // Modular GW-bit arithmetic is exact: |G| <= 4*(2^DW-1) fits signed GW.
   always_comb begin
      gx = ext(p13) + (ext(p23) << 1) + ext(in_pixel)
         - ext(t0_q) - (ext(m0_q) << 1) - ext(b0_q);
      gy = ext(b0_q) + (ext(b1_q) << 1) + ext(in_pixel)
         - ext(t0_q) - (ext(t1_q) << 1) - ext(p13);
      ax = gx[GW-1] ? -gx : gx;
      ay = gy[GW-1] ? -gy : gy;
      mag = '0;
      unique case (mode)
         2'd0:    mag = ax + ay;
         2'd1:    mag = ax;
         2'd2:    mag = ay;
         default: mag = (ax > ay) ? ax : ay;
      endcase
   end

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      ov_d   = ov_q && !out_ready;
      px_d   = px_q;
      last_d = last_q;
      if (acc) begin
         if (c == CMAX) begin
            col_d = '0;
            row_d = (r == RMAX) ? '0 : r + RW'(1);
         end else begin
            col_d = c + CW'(1);
            row_d = r;
         end
         if (inner) begin
            ov_d   = 1'b1;
            px_d   = (mag > SAT) ? SAT[DW-1:0] : mag[DW-1:0];
            last_d = (r == RMAX) && (c == CMAX);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q  <= '0;
         row_q  <= '0;
         ov_q   <= 1'b0;
         px_q   <= '0;
         last_q <= 1'b0;
         t0_q   <= '0;
         t1_q   <= '0;
         m0_q   <= '0;
         m1_q   <= '0;
         b0_q   <= '0;
         b1_q   <= '0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         ov_q   <= ov_d;
         px_q   <= px_d;
         last_q <= last_d;
         if (acc) begin
            t0_q <= t1_q;
            t1_q <= p13;
            m0_q <= m1_q;
            m1_q <= p23;
            b0_q <= b1_q;
            b1_q <= in_pixel;
         end
      end
   end

   // Line buffers carry no reset; rows are always rewritten before use.
   always_ff @(posedge clk) begin
      if (acc) begin
         lb2_q[c] <= p23;
         lb1_q[c] <= in_pixel;
      end
   end

endmodule
